// File: rtl/screen_ram.sv
// -----------------------------------------------------------------------------
// screen_ram
//   8K x 16 frame store for the Hack screen window (0x4000-0x5FFF). Each word
//   holds 16 pixels, and bit 0 is the leftmost pixel.
//
//   Access ports:
//     * The CPU port is synchronous and read-first.
//       - oCPU_DATA has a latency of one rising edge.
//       - A write always commits on the rising edge. It is never stalled.
//     * The VGA scanout port reads on the falling edge.
//       - An address presented after rising edge T has valid data before
//         rising edge T+1.
//     * The fill engine sweeps the whole array with one constant word.
//       - The engine shares the single write port with the CPU.
//       - The CPU wins any collision, and the sweep pointer holds that cycle.
//
//   There is no valid/ready handshake anywhere in this block. The CPU write
//   enable is always accepted. A fill request is acted on in the cycle it is
//   sampled. A second request during a sweep restarts the sweep.
//
//   Ports:
//     iCLK       system clock (25 MHz pixel clock domain)
//     iRST_N     async active-low reset (memory contents are not reset)
//     iCPU_ADDR  CPU word address, iCPU_DATA write data, iCPU_WE write enable
//     oCPU_DATA  registered CPU read data
//     iCLR       fill request; iCLR_VAL is the fill word captured with it
//     oBUSY      fill engine active
//     oDONE      one-cycle pulse after the last fill write
//     iVGA_ADDR  scanout word address, oVGA_DATA scanout data
//     oDBG_FILL  debug view of the fill FSM (1 = FILL, 0 = IDLE)
//
//   Build option:
//     SCREEN_RAM_INIT_CLEAR_EN
//       When defined, the engine sweeps INIT_VAL through the array on every
//       reset release, exactly as if iCLR had been asserted.
// -----------------------------------------------------------------------------
module screen_ram #(
  parameter int              ADDR_W   = 13,
  parameter int              DATA_W   = 16,
  parameter logic [15:0]     INIT_VAL = 16'h0000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [ADDR_W-1:0] iCPU_ADDR,
  input  logic [DATA_W-1:0] iCPU_DATA,
  input  logic              iCPU_WE,
  output logic [DATA_W-1:0] oCPU_DATA,
  input  logic              iCLR,
  input  logic [DATA_W-1:0] iCLR_VAL,
  output logic              oBUSY,
  output logic              oDONE,
  input  logic [ADDR_W-1:0] iVGA_ADDR,
  output logic [DATA_W-1:0] oVGA_DATA,
  output logic              oDBG_FILL
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              busy_d, done_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              fill_we;

`ifdef SCREEN_RAM_INIT_CLEAR_EN
  // Set by reset. It turns the first IDLE cycle after release into a sweep
  // start that uses INIT_VAL.
  logic init_q;
  logic init_d;
`else
  logic [15:0] unused_init_val;
  assign unused_init_val = INIT_VAL;
`endif

  // ---------------------------------------------------------------------------
  // Fill FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
`ifdef SCREEN_RAM_INIT_CLEAR_EN
      init_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      fill_q  <= fill_d;
      oBUSY   <= busy_d;
      oDONE   <= done_d;
`ifdef SCREEN_RAM_INIT_CLEAR_EN
      init_q  <= init_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Fill FSM: next state and write-port arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    busy_d  = oBUSY;
    done_d  = 1'b0;
    fill_we = 1'b0;
`ifdef SCREEN_RAM_INIT_CLEAR_EN
    init_d  = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (iCLR) begin
          fill_d  = iCLR_VAL;
          ptr_d   = '0;
          state_d = ST_FILL;
          busy_d  = 1'b1;
        end
`ifdef SCREEN_RAM_INIT_CLEAR_EN
        else if (init_q) begin
          fill_d  = DATA_W'(INIT_VAL);
          ptr_d   = '0;
          state_d = ST_FILL;
          busy_d  = 1'b1;
        end
`endif
      end

      ST_FILL: begin
        if (iCLR) begin
          // Restart from the top with the new word. No write happens this
          // cycle, and the engine stays busy.
          fill_d = iCLR_VAL;
          ptr_d  = '0;
        end else if (!iCPU_WE) begin
          // A CPU write owns the port this cycle, so the sweep only advances
          // when the CPU is not writing.
          fill_we = 1'b1;
          ptr_d   = ptr_q + 1'b1;          // wraps to 0 after DEPTH-1
          if (ptr_q == {ADDR_W{1'b1}}) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    mem_we    = iCPU_WE | fill_we;
    mem_waddr = iCPU_WE ? iCPU_ADDR : ptr_q;
    mem_wdata = iCPU_WE ? iCPU_DATA : fill_q;
  end

  assign oDBG_FILL = (state_q == ST_FILL);

  // ---------------------------------------------------------------------------
  // Storage: a single write port on the rising edge. The contents are not
  // reset, so they survive iRST_N.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // The CPU read samples the array on the same edge as a write, so it returns
  // the old word.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oCPU_DATA <= '0;
    end else begin
      oCPU_DATA <= mem[iCPU_ADDR];
    end
  end

  // The scanout read sits half a cycle after the write edge. This makes a
  // write from rising edge T visible here, and it gives the data to the VGA
  // stage before rising edge T+1.
  always_ff @(negedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oVGA_DATA <= '0;
    end else begin
      oVGA_DATA <= mem[iVGA_ADDR];
    end
  end

endmodule
